// File: rtl/stage2_ctrl_pkg.sv
// Shared definitions for the stage-2 convolution controller.
// Holds the channel/width constants, derived counter widths, the controller
// FSM state encoding and sign-extension helpers for kernel results and biases.
package stage2_ctrl_pkg;

  localparam int unsigned CI          = 3;
  localparam int unsigned CO          = 3;
  localparam int unsigned KACC_BW     = 24;
  localparam int unsigned ACC_BW      = 32;
  localparam int unsigned BIAS_BW     = 16;
  localparam int unsigned NPIX_BW     = 10;
  localparam int unsigned OFIFO_DEPTH = 4;

  localparam int unsigned CI_W    = (CI > 1) ? $clog2(CI) : 1;
  localparam int unsigned CO_W    = (CO > 1) ? $clog2(CO) : 1;
  localparam int unsigned WADDR_W = (CO * CI > 1) ? $clog2(CO * CI) : 1;
  // Occupancy / in-flight counters must be able to hold OFIFO_DEPTH itself.
  localparam int unsigned OCC_W   = $clog2(OFIFO_DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  function automatic logic signed [ACC_BW-1:0] sext_kacc(input logic signed [KACC_BW-1:0] v);
    return {{(ACC_BW - KACC_BW){v[KACC_BW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_BW-1:0] sext_bias(input logic signed [BIAS_BW-1:0] v);
    return {{(ACC_BW - BIAS_BW){v[BIAS_BW-1]}}, v};
  endfunction

endpackage

// File: rtl/stage2_ctrl_ofifo.sv
// Small synchronous output FIFO for the stage-2 controller.
// Ports: clk, reset_n (async active-low), push_i/data_i write side,
// pop_i/valid_o/data_o read side (data_o is 0 while empty), count_o occupancy.
module stage2_ctrl_ofifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [$clog2(Depth):0] count_q;
  logic                  do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/stage2_conv_ctrl.sv
// Stage-2 5x5 convolution sequencer and channel accumulator.
// Issues windows to the kernel (pixel-major, then co, then ci) with a weight
// address, sums kernel results over CI input channels, adds the per-co bias and
// queues one result per (pixel, co) in an output FIFO. Issue of a group's last
// channel is throttled by FIFO credit so the FIFO can never overflow.
// Ports: clk, reset_n; i_start/i_npix/o_busy/o_done frame control;
// i_win_valid/o_win_ready/o_k_valid/o_w_addr issue side; i_k_valid/i_k_acc
// kernel results; i_bias packed biases; o_ot_valid/i_ot_ready/o_ot_data/o_ot_co
// output stream.
// Build option: define STAGE2_CTRL_RELU_EN to clamp negative results to 0.
module stage2_conv_ctrl
  import stage2_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic [NPIX_BW-1:0]        i_npix,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic                      i_win_valid,
  output logic                      o_win_ready,
  output logic                      o_k_valid,
  output logic [WADDR_W-1:0]        o_w_addr,
  input  logic                      i_k_valid,
  input  logic signed [KACC_BW-1:0] i_k_acc,
  input  logic [CO*BIAS_BW-1:0]     i_bias,
  output logic                      o_ot_valid,
  input  logic                      i_ot_ready,
  output logic signed [ACC_BW-1:0]  o_ot_data,
  output logic [CO_W-1:0]           o_ot_co
);

  state_e                    state_q;
  logic [NPIX_BW-1:0]        npix_q, pix_q;
  logic [CI_W-1:0]           ci_q, rx_ci_q;
  logic [CO_W-1:0]           co_q, rx_co_q;
  logic [OCC_W-1:0]          inflight_q, occ;
  logic signed [ACC_BW-1:0]  acc_q, acc_next, result, push_val;
  logic signed [BIAS_BW-1:0] bias_sel;
  logic                      busy_q, done_q;
  logic                      credit_zero, hs, last_win, issue_grp, rx_en, push, pop;
  logic [ACC_BW+CO_W-1:0]    fifo_rdata;

  // Credit = depth - occupancy - groups in flight; only zero matters.
  assign credit_zero = ({1'b0, occ} + {1'b0, inflight_q}) >= (OCC_W + 1)'(OFIFO_DEPTH);
  assign o_win_ready = (state_q == StRun) && !((ci_q == CI_W'(CI - 1)) && credit_zero);
  assign hs          = i_win_valid && o_win_ready;
  assign o_k_valid   = hs;
  assign issue_grp   = hs && (ci_q == CI_W'(CI - 1));
  assign last_win    = (pix_q == npix_q - NPIX_BW'(1)) && (co_q == CO_W'(CO - 1)) &&
                       (ci_q == CI_W'(CI - 1));
  assign o_w_addr    = WADDR_W'(co_q) * WADDR_W'(CI) + WADDR_W'(ci_q);
  assign o_busy      = busy_q;
  assign o_done      = done_q;

  // Frame FSM and issue counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      npix_q  <= '0;
      pix_q   <= '0;
      ci_q    <= '0;
      co_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            npix_q <= i_npix;
            pix_q  <= '0;
            ci_q   <= '0;
            co_q   <= '0;
            busy_q <= 1'b1;
            if (i_npix == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (hs) begin
            if (ci_q == CI_W'(CI - 1)) begin
              ci_q <= '0;
              if (co_q == CO_W'(CO - 1)) begin
                co_q  <= '0;
                pix_q <= pix_q + NPIX_BW'(1);
              end else begin
                co_q <= co_q + CO_W'(1);
              end
            end else begin
              ci_q <= ci_q + CI_W'(1);
            end
            if (last_win) state_q <= StDrain;
          end
        end
        StDrain: begin
          if ((inflight_q == '0) && (occ == '0)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Receive side: kernel preserves order, so rx counters track issue order.
  assign rx_en    = i_k_valid && ((state_q == StRun) || (state_q == StDrain));
  assign push     = rx_en && (rx_ci_q == CI_W'(CI - 1));
  assign bias_sel = i_bias[int'(rx_co_q) * BIAS_BW +: BIAS_BW];
  assign acc_next = (rx_ci_q == '0) ? sext_kacc(i_k_acc) : acc_q + sext_kacc(i_k_acc);
  assign result   = acc_next + sext_bias(bias_sel);

`ifdef STAGE2_CTRL_RELU_EN
  assign push_val = result[ACC_BW-1] ? '0 : result;
`else
  assign push_val = result;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ci_q    <= '0;
      rx_co_q    <= '0;
      acc_q      <= '0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + OCC_W'(issue_grp) - OCC_W'(push);
      if (rx_en) begin
        acc_q <= acc_next;
        if (rx_ci_q == CI_W'(CI - 1)) begin
          rx_ci_q <= '0;
          rx_co_q <= (rx_co_q == CO_W'(CO - 1)) ? '0 : rx_co_q + CO_W'(1);
        end else begin
          rx_ci_q <= rx_ci_q + CI_W'(1);
        end
      end
    end
  end

  assign pop = o_ot_valid && i_ot_ready;

  stage2_ctrl_ofifo #(
    .Width (ACC_BW + CO_W),
    .Depth (OFIFO_DEPTH)
  ) u_ofifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({rx_co_q, push_val}),
    .pop_i   (pop),
    .valid_o (o_ot_valid),
    .data_o  (fifo_rdata),
    .count_o (occ)
  );

  assign o_ot_data = fifo_rdata[ACC_BW-1:0];
  assign o_ot_co   = fifo_rdata[ACC_BW+CO_W-1:ACC_BW];

`ifndef SYNTHESIS
  k_valid_in_frame: assert property (@(posedge clk) disable iff (!reset_n)
    i_k_valid |-> (state_q inside {StRun, StDrain}))
    else $error("kernel result arrived outside RUN/DRAIN");
`endif

endmodule

// File: tb/tb_stage2_conv_ctrl.sv
// Bench for stage2_conv_ctrl: acts as window source, 5-cycle kernel and output
// sink. A reference model derives expected results from window order and
// plain integer sums; a monitor pops a scoreboard on every output handshake.
module tb_stage2_conv_ctrl;
  import stage2_ctrl_pkg::*;

  logic                      clk, reset_n, i_start, o_busy, o_done;
  logic [NPIX_BW-1:0]        i_npix;
  logic                      i_win_valid, o_win_ready, o_k_valid;
  logic [WADDR_W-1:0]        o_w_addr;
  logic                      i_k_valid;
  logic signed [KACC_BW-1:0] i_k_acc;
  logic [CO*BIAS_BW-1:0]     i_bias;
  logic                      o_ot_valid, i_ot_ready;
  logic signed [ACC_BW-1:0]  o_ot_data;
  logic [CO_W-1:0]           o_ot_co;

  stage2_conv_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_npix      (i_npix),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_win_valid (i_win_valid),
    .o_win_ready (o_win_ready),
    .o_k_valid   (o_k_valid),
    .o_w_addr    (o_w_addr),
    .i_k_valid   (i_k_valid),
    .i_k_acc     (i_k_acc),
    .i_bias      (i_bias),
    .o_ot_valid  (o_ot_valid),
    .i_ot_ready  (i_ot_ready),
    .o_ot_data   (o_ot_data),
    .o_ot_co     (o_ot_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint co;
  } exp_t;

  int     n_pass = 0, n_total = 0;
  exp_t   exp_q[$];
  longint acc_src[$];
  longint got_q[$];
  longint got_co[$];
  longint bias_arr[CO];
  longint ref_sum = 0;
  int     hs_cnt = 0, occ_m = 0, done_cnt = 0;
  bit     pv[5], pl[5];
  longint pa[5];
  bit     cap_v, cap_l;
  longint cap_a;
  int     ci_m, co_m;
  logic signed [31:0] res_m;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bias();
    for (int c = 0; c < CO; c++) i_bias[c*BIAS_BW +: BIAS_BW] = BIAS_BW'(bias_arr[c]);
  endtask

  task automatic start_frame(input int npix);
    got_q.delete();
    got_co.delete();
    hs_cnt  = 0;
    i_npix  = NPIX_BW'(npix);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic run_frame(input int win_pct, input int rdy_pct, input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      i_win_valid = ($urandom_range(99) < win_pct);
      i_ot_ready  = ($urandom_range(99) < rdy_pct);
      step();
      n++;
    end
    i_win_valid = 1'b0;
    i_ot_ready  = 1'b1;
    check("done_within_budget", longint'(done_cnt != d0), 1);
    step();
    step();
    check("single_done_pulse", done_cnt - d0, 1);
    check("idle_after_done", o_busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic fill_random(input int n);
    logic signed [KACC_BW-1:0] r;
    for (int i = 0; i < n; i++) begin
      r = KACC_BW'($urandom);
      acc_src.push_back(longint'(r));
    end
  endtask

  // Kernel model: records each accepted window, computes the reference
  // result per group and returns the acc 5 cycles later.
  initial begin
    for (int i = 0; i < 5; i++) begin pv[i] = 0; pl[i] = 0; pa[i] = 0; end
    forever begin
      @(negedge clk);
      cap_v = 0;
      cap_l = 0;
      cap_a = 0;
      if (!reset_n) begin
        for (int i = 0; i < 5; i++) begin pv[i] = 0; pl[i] = 0; end
        ref_sum = 0;
      end else if (o_k_valid) begin
        ci_m = hs_cnt % CI;
        co_m = (hs_cnt / CI) % CO;
        check("w_addr", o_w_addr, co_m * CI + ci_m);
        if (acc_src.size() == 0) begin
          check("window_count_overrun", 1, 0);
          cap_a = 0;
        end else begin
          cap_a = acc_src.pop_front();
        end
        ref_sum += cap_a;
        if (ci_m == CI - 1) begin
          res_m = 32'(ref_sum + bias_arr[co_m]);
`ifdef STAGE2_CTRL_RELU_EN
          if (res_m < 0) res_m = 0;
`endif
          exp_q.push_back('{data: longint'(res_m), co: co_m});
          ref_sum = 0;
          cap_l   = 1;
        end
        hs_cnt++;
        cap_v = 1;
      end
      @(posedge clk);
      #1;
      for (int i = 4; i > 0; i--) begin pv[i] = pv[i-1]; pl[i] = pl[i-1]; pa[i] = pa[i-1]; end
      pv[0] = cap_v;
      pl[0] = cap_l;
      pa[0] = cap_a;
      i_k_valid = pv[4];
      i_k_acc   = pa[4][KACC_BW-1:0];
    end
  end

  // Output monitor with an occupancy model (pushes from last-channel kernel
  // results, pops from output handshakes).
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        occ_m = 0;
      end else begin
        check("ot_valid_vs_occupancy", o_ot_valid, longint'(occ_m > 0));
        if (o_done) done_cnt++;
        if (o_ot_valid && i_ot_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ot_data", o_ot_data, e.data);
            check("ot_co", o_ot_co, e.co);
          end
          got_q.push_back(longint'(o_ot_data));
          got_co.push_back(longint'(o_ot_co));
          occ_m--;
        end
        if (i_k_valid && pl[4]) occ_m++;
        if (occ_m > OFIFO_DEPTH) check("fifo_overflow", occ_m, OFIFO_DEPTH);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [BIAS_BW-1:0] rb;
    reset_n = 0; i_start = 0; i_npix = '0; i_win_valid = 0; i_ot_ready = 0;
    i_k_valid = 0; i_k_acc = '0; i_bias = '0;
    for (int c = 0; c < CO; c++) bias_arr[c] = 0;
    repeat (2) step();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_win_ready", o_win_ready, 0);
    check("rst_k_valid", o_k_valid, 0);
    check("rst_ot_valid", o_ot_valid, 0);
    check("rst_ot_data", o_ot_data, 0);
    check("rst_ot_co", o_ot_co, 0);
    reset_n = 1;
    step();

    // Single pixel, all accs 10, biases 1,2,3.
    for (int c = 0; c < CO; c++) bias_arr[c] = c + 1;
    set_bias();
    for (int i = 0; i < CO * CI; i++) acc_src.push_back(10);
    start_frame(1);
    run_frame(100, 100, 200);
    check("basic_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("basic_r0", got_q[0], 31);
      check("basic_r1", got_q[1], 32);
      check("basic_r2", got_q[2], 33);
      check("basic_t2", got_co[2], 2);
    end

    // Sign extension of kernel results.
    for (int c = 0; c < CO; c++) bias_arr[c] = 0;
    set_bias();
    for (int g = 0; g < CO; g++) begin
      acc_src.push_back(longint'(24'sh7FFFFF));
      acc_src.push_back(longint'(24'sh7FFFFF));
      acc_src.push_back(-1);
    end
    start_frame(1);
    run_frame(100, 100, 200);
    if (got_q.size() > 0) check("sext_r0", got_q[0], 64'h0000_0000_00FF_FFFD);
    else check("sext_count", got_q.size(), 3);

    // Negative result, with or without clamping.
    for (int c = 0; c < CO; c++) bias_arr[c] = 2;
    set_bias();
    for (int i = 0; i < CO * CI; i++) acc_src.push_back(-5);
    start_frame(1);
    run_frame(100, 100, 200);
    if (got_q.size() > 0) begin
`ifdef STAGE2_CTRL_RELU_EN
      check("neg_r0", got_q[0], 0);
`else
      check("neg_r0", got_q[0], -13);
`endif
    end else check("neg_count", got_q.size(), 3);

    // Zero-pixel frame: IDLE -> DONE -> IDLE, no window accepted.
    i_win_valid = 1;
    start_frame(0);
    check("npix0_done", o_done, 1);
    check("npix0_busy", o_busy, 1);
    step();
    check("npix0_done_clear", o_done, 0);
    check("npix0_idle", o_busy, 0);
    check("npix0_no_windows", hs_cnt, 0);
    i_win_valid = 0;
    step();

    // Output blocked: credit stalls issue at the last channel.
    for (int c = 0; c < CO; c++) begin rb = BIAS_BW'($urandom); bias_arr[c] = rb; end
    set_bias();
    fill_random(4 * CO * CI);
    i_win_valid = 1;
    i_ot_ready  = 0;
    start_frame(4);
    repeat (60) step();
    check("stall_windows", hs_cnt, OFIFO_DEPTH * CI + CI - 1);
    check("stall_occupancy", occ_m, OFIFO_DEPTH);
    check("stall_win_ready", o_win_ready, 0);
    check("stall_busy", o_busy, 1);
    run_frame(100, 100, 1000);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      int np;
      for (int c = 0; c < CO; c++) begin rb = BIAS_BW'($urandom); bias_arr[c] = rb; end
      set_bias();
      np = $urandom_range(5, 1);
      fill_random(np * CO * CI);
      start_frame(np);
      run_frame(70, 60, 3000);
    end

    // Reset in the middle of a frame, then a fresh frame.
    fill_random(4 * CO * CI);
    i_win_valid = 1;
    i_ot_ready  = 1;
    start_frame(4);
    repeat (9) step();
    reset_n = 0;
    i_win_valid = 0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_win_ready", o_win_ready, 0);
    check("mid_rst_k_valid", o_k_valid, 0);
    check("mid_rst_ot_valid", o_ot_valid, 0);
    check("mid_rst_ot_data", o_ot_data, 0);
    check("mid_rst_ot_co", o_ot_co, 0);
    exp_q.delete();
    acc_src.delete();
    step();
    check("mid_rst_idle", o_busy, 0);
    step();
    reset_n = 1;
    step();
    fill_random(2 * CO * CI);
    start_frame(2);
    run_frame(80, 80, 2000);
    check("post_rst_count", got_q.size(), 2 * CO);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage2_conv_ctrl.md
Name: stage2_conv_ctrl

Overview:
Sequencer and channel accumulator for the stage-2 5x5 convolution kernel. It accepts a stream of 5x5 feature-map windows and forwards each one to the single kernel instance with a valid pulse and a matching weight address. It sums the kernel's per-channel results across all input channels, adds a per-output-channel bias, and pushes one result per (pixel, output channel) into an output FIFO with valid/ready handshake.

Parameters:
CI, 3, input channels summed per output
CO, 3, output channels per pixel
KACC_BW, 24, kernel accumulator width (kernel output)
ACC_BW, 32, channel-sum / output width
BIAS_BW, 16, signed bias width
NPIX_BW, 10, pixel-count width
OFIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  start-pulse for one frame; honoured only in IDLE
i_npix  in  NPIX_BW  output pixels in the frame; sampled on accepted i_start; 0 means go straight to DONE
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse when the frame completes
i_win_valid  in  1  upstream window available; order is pixel-major, then co, then ci
o_win_ready  out  1  controller accepts the window this cycle
o_k_valid  out  1  kernel i_in_valid; equals i_win_valid & o_win_ready
o_w_addr  out  clog2(CO*CI)  weight address = co*CI+ci of the current window; combinational from counters
i_k_valid  in  1  kernel o_ot_valid
i_k_acc  in  KACC_BW signed  kernel o_ot_kernel_acc
i_bias  in  CO*BIAS_BW  packed signed biases; co0 in the LSBs
o_ot_valid  out  1  output FIFO not empty
i_ot_ready  in  1  downstream accepts
o_ot_data  out  ACC_BW signed  FIFO head result
o_ot_co  out  clog2(CO)  output channel of the head entry

Behaviour:
- Reset: state IDLE. All counters, accumulator, FIFO pointers and credits are cleared. o_busy, o_done, o_win_ready, o_k_valid, o_ot_valid are 0. o_ot_data and o_ot_co are 0. A reset mid-frame discards in-flight results; the kernel's own reset flushes its pipeline.
- FSM states:
  - IDLE: on i_start, latch i_npix. Go to RUN, or to DONE if i_npix==0.
  - RUN: issue windows. Issue counters ci (wraps at CI-1), co (wraps at CO-1, advancing when ci wraps) and pix advance on each handshake. After the handshake with pix==npix-1, co==CO-1, ci==CI-1, go to DRAIN.
  - DRAIN: o_win_ready=0. Wait until in-flight group count is 0 and the FIFO is empty, then go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- Issue rule: o_win_ready=1 in RUN, except when ci==CI-1 and credit==0.
  - credit = OFIFO_DEPTH − FIFO occupancy − groups in flight.
  - A group counts as in flight from its last-channel issue until its FIFO push.
  - This guarantees the FIFO never overflows. The kernel pipeline itself is never stalled.
- Receive side: independent rx_ci/rx_co counters advance on each i_k_valid.
  - The kernel preserves order, so the rx counters mirror the issue counters with a 5-cycle lag.
  - On rx_ci==0, acc = sext(i_k_acc); otherwise acc += sext(i_k_acc). Sign-extend from KACC_BW to ACC_BW; wrap-around two's-complement, no saturation.
  - On rx_ci==CI-1, result = acc_next + sext(bias[rx_co]) is pushed into the FIFO with tag rx_co, and the in-flight count decrements in the same cycle.
- FIFO: push and pop in the same cycle are allowed and leave occupancy unchanged. Pop happens when o_ot_valid & i_ot_ready. A push to a full FIFO cannot occur by construction; the bench asserts this.
- Latency: the last-channel kernel result appears at o_ot_valid 1 cycle later when the FIFO was empty; first-word fall-through is not used.
- Simultaneous i_start while busy: ignored.
- i_k_valid outside RUN/DRAIN: ignored; raises a sim-only error.

Optional Feature:
STAGE2_CTRL_RELU_EN.
- Defined: the FIFO push value is max(result, 0), so negative sums are written as 0.
- Undefined: the signed result is pushed unchanged.
- Credit, latency and tag behaviour are identical in both cases.

Decomposition:
- Shared package stage2_ctrl_pkg holds: FSM state encoding (IDLE/RUN/DRAIN/DONE), CI/CO/ACC_BW defaults, the KACC_BW→ACC_BW sign-extend helper, and the CO_W/CI_W clog2 constants.
- One natural sub-module: stage2_ctrl_ofifo, a synchronous FIFO with ACC_BW+CO_W width and an occupancy output.

Test Plan:
- Single pixel, CI=3, CO=3, all kernel accs 10, bias {1,2,3} -> three outputs 31,32,33 with tags 0,1,2; o_done is pulsed once after the third pop.
- i_ot_ready held 0, npix=4 -> exactly OFIFO_DEPTH=4 results stored. o_win_ready stays low at ci==2 while credit==0, no FIFO overflow occurs, and the frame resumes when i_ot_ready rises.
- Accs 0x7FFFFF, 0x7FFFFF, −1 with bias 0 -> output 0x00FFFFFD, confirming sign-extension.
- STAGE2_CTRL_RELU_EN defined, accs −5,−5,−5, bias 2 -> output 0. Undefined -> output −13.
- i_npix=0 -> IDLE→DONE→IDLE, o_done pulses, no window is accepted.
- reset_n asserted mid-RUN with 2 groups in flight -> all outputs 0 and FSM in IDLE next cycle; a fresh i_start then produces correct results.
